// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the byte-serial memory port arbiter.
// Size codes, FSM states, owner ids and the size-to-byte-count helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] A_IDLE  = 2'd0;
  localparam logic [1:0] A_XFER  = 2'd1;
  localparam logic [1:0] A_DRAIN = 2'd2;
  localparam logic [1:0] A_RESP  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Reserved code 3 falls through to the word case.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter with registered priority.
// Index 0 is the I port, index 1 the D port; prio names the favoured index.
module rr_arbiter2 #(
  parameter bit first = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

  // After any grant the other port becomes favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio <= first;
    else if (en && (|gnt)) prio <= gnt[0];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between fetch (I) and load/store (D) ports,
// serialising word requests into MSB-first byte accesses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int addr_width = 32,
  parameter int width      = 32,
  parameter bit d_first    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [addr_width-1:0] i_addr,
  input  logic                  i_flush,
  output logic                  i_gnt,
  output logic                  i_valid,
  output logic [width-1:0]      i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_size,
  input  logic [addr_width-1:0] d_addr,
  input  logic [width-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [width-1:0]      d_rdata,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  logic [1:0]            state;
  logic                  owner;
  logic                  we_q;
  logic [2:0]            n_q;
  logic [2:0]            cnt;
  logic [addr_width-1:0] base_q;
  logic [width-1:0]      wdata_q;
  logic [width-1:0]      acc;
  logic                  rd_pend;
  logic                  flushed;

  logic [1:0]            arb_req;
  logic [1:0]            arb_gnt;
  logic                  arb_en;
  logic [2:0]            byte_idx;
  logic [width-1:0]      wsh;
  logic [width-1:0]      acc_next;
  logic                  i_cancel;

  assign arb_en   = (state == A_IDLE);
  assign arb_req  = {d_req, i_req & ~i_flush};
  assign byte_idx = n_q - 3'd1 - cnt;
  assign wsh      = wdata_q >> {byte_idx, 3'b000};
  // rd_pend marks the cycle in which mem_rdata carries the previous strobe's byte.
  assign acc_next = {acc[width-9:0], mem_rdata};
  assign i_cancel = flushed | i_flush;

  rr_arbiter2 #(.first(d_first)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .en  (arb_en),
    .gnt (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= A_IDLE;
      owner     <= OWN_I;
      we_q      <= 1'b0;
      n_q       <= 3'd0;
      cnt       <= 3'd0;
      base_q    <= '0;
      wdata_q   <= '0;
      acc       <= '0;
      rd_pend   <= 1'b0;
      flushed   <= 1'b0;
      i_gnt     <= 1'b0;
      i_valid   <= 1'b0;
      i_rdata   <= '0;
      d_gnt     <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
    end else begin
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      rd_pend   <= mem_re;
      if (rd_pend) acc <= acc_next;
      if (state != A_IDLE && owner == OWN_I && i_flush) flushed <= 1'b1;

      case (state)
        A_IDLE: begin
          if (|arb_gnt) begin
            owner   <= arb_gnt[1];
            i_gnt   <= arb_gnt[0];
            d_gnt   <= arb_gnt[1];
            base_q  <= arb_gnt[1] ? d_addr : i_addr;
            we_q    <= arb_gnt[1] & d_we;
            wdata_q <= d_wdata;
            n_q     <= arb_gnt[1] ? size_bytes(d_size) : 3'd4;
            cnt     <= 3'd0;
            acc     <= '0;
            flushed <= 1'b0;
            state   <= A_XFER;
          end
        end

        A_XFER: begin
          mem_addr <= base_q + addr_width'(cnt);
          if (we_q) begin
            mem_we    <= 1'b1;
            mem_wdata <= wsh[7:0];
          end else begin
            mem_re <= 1'b1;
          end
          cnt <= cnt + 3'd1;
          if (cnt == n_q - 3'd1) state <= we_q ? A_RESP : A_DRAIN;
        end

        // A cancelled fetch has nothing to respond with, so it skips RESP.
        A_DRAIN: begin
          if (owner == OWN_I && i_cancel) state <= A_IDLE;
          else state <= A_RESP;
        end

        A_RESP: begin
          state <= A_IDLE;
          if (owner == OWN_D) begin
            d_valid <= 1'b1;
            if (!we_q) d_rdata <= acc_next;
          end else if (!i_cancel) begin
            i_valid <= 1'b1;
            i_rdata <= acc_next;
          end
        end

        default: state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-schedule model of the arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_gnt, i_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_valid;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [7:0] env_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    env_mem[a] = v;
    ref_mem[a] = v;
  endtask

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= env_rd(mem_addr);
    if (mem_we) env_mem[mem_addr] = mem_wdata;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ig, dg, iv, dv, re, we;
    logic [31:0] addr;
    logic [7:0]  wd;
  } exp_t;

  exp_t        slot [64];
  int          cyc, free_at, t_g, t_v, t_n;
  bit          t_busy, t_own, t_we, t_fl, prio;
  logic [31:0] t_data, exp_ird, exp_drd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; free_at = 0; t_busy = 0; t_fl = 0; prio = 1'b1;
      exp_ird = '0; exp_drd = '0;
      foreach (slot[k]) slot[k] = '0;
    end else begin
      bit ei, ed;
      logic [31:0] base, a, sh;
      cyc++;
      slot[(cyc + 40) & 63] = '0;
      if (slot[(cyc - 1) & 63].we) ref_mem[slot[(cyc - 1) & 63].addr] = slot[(cyc - 1) & 63].wd;
      if (t_busy) begin
        if (!t_own && i_flush) t_fl = 1;
        if (!t_own && t_fl && cyc == t_g + 5) begin
          t_busy = 0; free_at = cyc + 1;
        end else if (cyc == t_v) begin
          t_busy = 0; free_at = cyc + 1;
          if (t_own) begin
            slot[cyc & 63].dv = 1'b1;
            if (!t_we) exp_drd = t_data;
          end else if (!t_fl) begin
            slot[cyc & 63].iv = 1'b1;
            exp_ird = t_data;
          end
        end
      end
      ei = i_req && !i_flush;
      ed = d_req;
      if (!t_busy && cyc >= free_at && (ei || ed)) begin
        t_own  = (ei && ed) ? prio : ed;
        prio   = !t_own;
        t_busy = 1; t_g = cyc; t_fl = 0; t_data = '0;
        t_we   = t_own && d_we;
        t_n    = !t_own ? 4 : (d_size == 2'd0) ? 1 : (d_size == 2'd1) ? 2 : 4;
        base   = t_own ? d_addr : i_addr;
        if (t_own) slot[cyc & 63].dg = 1'b1;
        else slot[cyc & 63].ig = 1'b1;
        for (int k = 0; k < t_n; k++) begin
          a = base + 32'(k);
          slot[(cyc + 1 + k) & 63].addr = a;
          if (t_we) begin
            sh = d_wdata >> (8 * (t_n - 1 - k));
            slot[(cyc + 1 + k) & 63].we = 1'b1;
            slot[(cyc + 1 + k) & 63].wd = sh[7:0];
          end else begin
            slot[(cyc + 1 + k) & 63].re = 1'b1;
            t_data = (t_data << 8) | {24'd0, ref_rd(a)};
          end
        end
        t_v = cyc + t_n + (t_we ? 1 : 2);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_t s;
      s = slot[cyc & 63];
      check("i_gnt", i_gnt, s.ig);
      check("d_gnt", d_gnt, s.dg);
      check("i_valid", i_valid, s.iv);
      check("d_valid", d_valid, s.dv);
      check("mem_re", mem_re, s.re);
      check("mem_we", mem_we, s.we);
      check("mem_addr", mem_addr, s.addr);
      check("mem_wdata", mem_wdata, s.wd);
      check("i_rdata", i_rdata, exp_ird);
      check("d_rdata", d_rdata, exp_drd);
      check("strobe_excl", mem_re & mem_we, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_zero(input string nm);
    check({nm, "_ctl"}, {i_gnt, i_valid, d_gnt, d_valid, mem_re, mem_we}, 0);
    check({nm, "_ird"}, i_rdata, 0);
    check({nm, "_drd"}, d_rdata, 0);
    check({nm, "_maddr"}, mem_addr, 0);
    check({nm, "_mwd"}, mem_wdata, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input bit is_d, input bit we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int gc, output int vc, output logic [31:0] rd);
    bit got;
    got = 0; gc = -100; vc = 0; rd = '0;
    @(negedge clk);
    if (is_d) begin d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (is_d ? d_gnt : i_gnt) begin
        got = 1; gc = cyc;
        if (is_d) d_req = 0; else i_req = 0;
      end
    end
    check("gnt_seen", got, 1);
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (is_d ? d_valid : i_valid) begin
        got = 1; vc = cyc; rd = is_d ? d_rdata : i_rdata;
      end
    end
    check("valid_seen", got, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 32'(($urandom_range(0, 63)));
    return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int          gc, vc, tg, dg, ng, nwe;
    bit          got, seen;
    logic [31:0] rd;
    logic [3:0]  order;

    rst = 1'b1; i_req = 0; i_addr = '0; i_flush = 0;
    d_req = 0; d_we = 0; d_size = 0; d_addr = '0; d_wdata = '0;
    poke(32'h0, 8'h11); poke(32'h1, 8'h22); poke(32'h2, 8'h33); poke(32'h3, 8'h44);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // fetch word at 0
    do_req(0, 0, 2'd2, 32'h0, '0, gc, vc, rd);
    check("fetch_lat", vc - gc, 6);
    check("fetch_data", rd, 32'h1122_3344);

    // store half at 0x10
    do_req(1, 1, 2'd1, 32'h10, 32'h0000_ABCD, gc, vc, rd);
    check("store_lat", vc - gc, 3);
    repeat (2) @(negedge clk);
    check("store_b0", env_rd(32'h10), 8'hAB);
    check("store_b1", env_rd(32'h11), 8'hCD);

    // contention after reset: D first, then alternating
    reset_dut();
    d_we = 0; d_size = 2'd2; d_addr = 32'h40; i_addr = 32'h44;
    @(negedge clk);
    i_req = 1; d_req = 1;
    order = '0; ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      if (d_gnt) begin order = {order[2:0], 1'b1}; ng++; end
      if (i_gnt) begin order = {order[2:0], 1'b0}; ng++; end
    end
    i_req = 0; d_req = 0;
    check("contend_count", ng, 4);
    check("contend_order", order, 4'b1010);
    repeat (10) @(negedge clk);

    // byte and word loads across the address wrap
    poke(32'hFFFF_FFFF, 8'h7E); poke(32'hFFFF_FFFE, 8'hA1);
    do_req(1, 0, 2'd0, 32'hFFFF_FFFF, '0, gc, vc, rd);
    check("wrap_byte", rd, 32'h0000_007E);
    check("load_lat", vc - gc, 3);
    do_req(1, 0, 2'd3, 32'hFFFF_FFFE, '0, gc, vc, rd);
    check("wrap_word", rd, 32'hA17E_1122);

    // flush mid-fetch with a pending load
    @(negedge clk);
    i_req = 1; i_addr = 32'h20;
    got = 0; tg = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (i_gnt) begin got = 1; tg = cyc; end
    end
    check("flush_gnt_seen", got, 1);
    i_req = 0; d_req = 1; d_we = 0; d_size = 2'd0; d_addr = 32'h5;
    got = 0; seen = 0; dg = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      i_flush = (k == 0);
      if (i_valid) seen = 1;
      if (d_gnt) begin got = 1; dg = cyc; d_req = 0; end
    end
    i_flush = 0;
    check("flush_dgnt_lat", dg - tg, 6);
    check("flush_no_ivalid", seen, 0);
    repeat (8) @(negedge clk);

    // reset in the middle of a word store
    poke(32'h30, 8'h00); poke(32'h31, 8'h00); poke(32'h32, 8'h00); poke(32'h33, 8'h00);
    @(negedge clk);
    d_req = 1; d_we = 1; d_size = 2'd2; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (d_gnt) begin got = 1; d_req = 0; end
    end
    nwe = 0;
    for (int k = 0; k < 20 && nwe < 2; k++) begin
      @(negedge clk);
      if (mem_we) nwe++;
    end
    check("rst_we_seen", nwe, 2);
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    seen = 0;
    repeat (2) begin @(negedge clk); if (d_valid) seen = 1; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (d_valid || mem_we) seen = 1; end
    check("rst_no_dvalid", seen, 0);
    check("rst_mem30", env_rd(32'h30), 8'hCA);
    check("rst_mem32", env_rd(32'h32), 8'h00);
    check("rst_mem33", env_rd(32'h33), 8'h00);
    do_req(0, 0, 2'd2, 32'h0, '0, gc, vc, rd);
    check("post_rst_lat", vc - gc, 6);
    check("post_rst_data", rd, 32'h1122_3344);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (i_req && i_gnt) i_req = 0;
      if (i_flush) i_flush = 0;
      else if ($urandom_range(0, 19) == 0) begin i_flush = 1; i_req = 0; end
      else if (!i_req && $urandom_range(0, 3) == 0) begin i_req = 1; i_addr = rand_addr(); end
      if (d_req && d_gnt) d_req = 0;
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 3));
        d_addr = rand_addr(); d_wdata = $urandom;
      end
    end
    @(negedge clk);
    i_req = 0; d_req = 0; i_flush = 0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single byte-wide program/data memory between two requesters: the instruction fetch unit (port I) and the load/store unit (port D).
- Accepts word-level requests from either port and serialises each into consecutive byte accesses, most significant byte first.
- Assembles read bytes into a word and returns it with a one-cycle valid pulse.
- Sits between the fetch/LSU front ends and the memory array; it is the only master driving the memory.

Parameters:
- addr_width, 32, byte address width for both ports and the memory.
- width, 32, maximum transfer width in bits; must be a multiple of 8.
- d_first, 1, port that owns round-robin priority after reset (1 = D, 0 = I).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_valid or i_flush.
- i_addr  in  addr_width  fetch byte address.
- i_flush  in  1  cancels the in-flight or pending fetch; its result is discarded.
- i_gnt  out  1  one-cycle pulse: fetch request accepted.
- i_valid  out  1  one-cycle pulse: i_rdata holds the fetched word.
- i_rdata  out  width  fetched word; always a full word.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- d_addr  in  addr_width  data byte address.
- d_wdata  in  width  store data, right-aligned.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: load data ready or store complete.
- d_rdata  out  width  load data, zero-extended and right-aligned.
- mem_addr  out  addr_width  memory byte address.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  read byte; valid exactly one cycle after mem_re.

Behaviour:
- Reset: all outputs are 0. State is IDLE, byte counter is 0, accumulator is 0, and round-robin priority is set by d_first. Reset takes effect asynchronously at any point. A transfer in flight when reset asserts is aborted: no valid pulse is produced and no further mem_we is issued.
- All outputs are registered. Requesters may change inputs only after their gnt pulse.
- State IDLE:
  - Only one requester active: grant it.
  - Both active: grant the port holding priority; priority then passes to the other port.
  - I is not granted while i_flush=1.
  - On a grant: gnt pulses for 1 cycle; addr, size, we and wdata are latched; N = byte count (1/2/4) is computed; the counter is cleared; state goes to XFER.
- State XFER (N cycles):
  - Cycle k drives mem_addr = base + k (mod 2^addr_width; wrap-around is legal).
  - Read: mem_re=1; the byte returned one cycle later is shifted into the accumulator, MSB first.
  - Write: mem_we=1 with mem_wdata = byte (N-1-k) of d_wdata, i.e. the most significant sized byte first.
  - After the last byte: a read goes to DRAIN; a write goes to RESP.
- State DRAIN (read only): captures the final byte, then goes to RESP.
- State RESP: raises the valid pulse of the owning port and presents data, then returns to IDLE. Data is held until the next valid pulse on that port.
- Latency: grant registered at cycle T.
  - Read: valid at T+N+2.
  - Write: valid at T+N+1.
  - Word fetch: valid 6 cycles after grant. Back-to-back grants are spaced N+3 cycles for reads and N+2 for writes.
- Flush:
  - i_flush=1 during an I transfer: the transfer runs to completion to keep memory timing fixed, and i_valid is suppressed.
  - Flush and a new fetch request in the same cycle: the new fetch is honoured only after flush deasserts.
- Arbitration of a port whose request drops before grant: that port is ignored; no grant is issued.
- Reserved size 3: behaves as size 2.
- Memory strobes: mem_re and mem_we are never both 1, and both are 0 in IDLE, DRAIN and RESP.

Decomposition:
- Package mem_pkg:
  - Size encoding constants: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State constants: A_IDLE, A_XFER, A_DRAIN, A_RESP.
  - Owner constants: OWN_I, OWN_D.
  - A function returning the byte count for a size code.
- Sub-module rr_arbiter2: 2-input round-robin with registered priority, the async rst, and an enable input (advance priority on grant). It is the natural split and is reusable for future DMA sharing.

Test Plan:
- Fetch only: memory bytes 0x00..0x03 = 11 22 33 44, i_req with i_addr=0 -> i_gnt at T; mem_re at T+1..T+4 on addresses 0..3; i_valid at T+6 with i_rdata=0x11223344.
- Store half: d_we=1, d_size=1, d_addr=0x10, d_wdata=0xABCD -> mem_we at 0x10=AB then 0x11=CD; d_valid at T+3; no mem_re at any point.
- Contention: i_req and d_req raised together after reset with d_first=1 -> D granted first, then I; repeating with both held alternates D, I, D, I.
- Load byte at wrap: d_addr=0xFFFFFFFF, byte 0x7E -> d_rdata=0x0000007E; a word load at 0xFFFFFFFE reads addresses FE, FF, 00, 01 in that order.
- Flush: assert i_flush at T+2 of a fetch -> no i_valid, memory sequence unchanged; an uncontested pending d_req is granted at T+6.
- Reset mid-store: assert rst after the 2nd mem_we of a word store -> all outputs 0 immediately, no d_valid; after release, a new request behaves as from power-up.
